// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: datapath width, execute-op encodings, writeback FSM states.
package nrisc_pkg;

  localparam int NRISC_TAM = 16;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic {IDLE, LOAD_WAIT} wb_state_t;

  // R0 is hardwired zero and R1 lives outside the file, so neither takes a write.
  function automatic logic rfd_writable(input logic [3:0] rfd);
    return rfd > 4'd1;
  endfunction

endpackage

// File: rtl/nrisc_wb_timeout.sv
// Load-wait watchdog: down-counter loaded on load accept, flags expiry at zero.
module nrisc_wb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th request cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= CW'(TIMEOUT - 1);
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/nrisc_writeback.sv
// NRISC writeback stage: ALU results and load data into the register-file write port.
// Optional load timeout with wb_err pulse is built when NRISC_WB_TIMEOUT_EN is defined.
import nrisc_pkg::*;

module nrisc_writeback #(
  parameter int TAM     = NRISC_TAM,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic [1:0]     ex_op,
  input  logic [TAM-1:0] ex_data,
  input  logic [3:0]     ex_rfd,
  output logic           mem_req,
  output logic [TAM-1:0] mem_addr,
  input  logic [TAM-1:0] mem_rdata,
  input  logic           mem_ack,
  output logic [TAM-1:0] REG_D,
  output logic [3:0]     REG_RFD,
  output logic           REG_Write,
  output logic           wb_busy,
  output logic           wb_err
);

  wb_state_t  state, state_nx;
  logic [3:0] pend_rfd;
  logic       take_alu, take_load, ld_done, ld_abort, expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ex_ready  = 1'b0;
    take_alu  = 1'b0;
    take_load = 1'b0;
    ld_done   = 1'b0;
    ld_abort  = 1'b0;
    case (state)
      IDLE: begin
        ex_ready = rst;
        if (ex_valid && rst) begin
          if (ex_op == OP_ALU) take_alu = 1'b1;
          else if (ex_op == OP_LOAD) begin
            take_load = 1'b1;
            state_nx  = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        // A late ack on the expiry cycle still completes the load.
        if (mem_ack) begin
          ld_done  = 1'b1;
          state_nx = IDLE;
        end else if (expired) begin
          ld_abort = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      REG_D     <= '0;
      REG_RFD   <= '0;
      REG_Write <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      pend_rfd  <= '0;
    end else begin
      REG_Write <= (take_alu && rfd_writable(ex_rfd)) || (ld_done && rfd_writable(pend_rfd));
      if (take_alu && rfd_writable(ex_rfd)) begin
        REG_D   <= ex_data;
        REG_RFD <= ex_rfd;
      end
      if (ld_done && rfd_writable(pend_rfd)) begin
        REG_D   <= mem_rdata;
        REG_RFD <= pend_rfd;
      end
      if (take_load) begin
        mem_addr <= ex_data;
        pend_rfd <= ex_rfd;
        mem_req  <= 1'b1;
      end else if (ld_done || ld_abort) begin
        mem_req  <= 1'b0;
      end
    end
  end

  assign wb_busy = mem_req;

`ifdef NRISC_WB_TIMEOUT_EN
  nrisc_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (take_load),
    .en      (state == LOAD_WAIT && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_err <= 1'b0;
    else      wb_err <= ld_abort;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign wb_err         = 1'b0;
`endif

endmodule

// File: tb/tb_nrisc_writeback.sv
// Directed bench for nrisc_writeback; timeout cases run when NRISC_WB_TIMEOUT_EN is defined.
module tb_nrisc_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic [15:0] ex_data;
  logic [3:0]  ex_rfd;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] REG_D;
  logic [3:0]  REG_RFD;
  logic        REG_Write;
  logic        wb_busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  nrisc_writeback #(.TAM(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_data   (ex_data),
    .ex_rfd    (ex_rfd),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .REG_D     (REG_D),
    .REG_RFD   (REG_RFD),
    .REG_Write (REG_Write),
    .wb_busy   (wb_busy),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d, input logic [3:0] rfd);
    ex_valid = v;
    ex_op    = op;
    ex_data  = d;
    ex_rfd   = rfd;
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, 2'b00, 16'h0, 4'h0);
    #2;
    check("rst_ex_ready",  ex_ready,  0);
    check("rst_reg_write", REG_Write, 0);
    check("rst_reg_d",     REG_D,     0);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_wb_err",    wb_err,    0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("post_rst_ex_ready", ex_ready, 1);

    // back-to-back ALU writes
    drive(1'b1, 2'b01, 16'h1111, 4'd2);  tick();
    check("alu0_we", REG_Write, 1); check("alu0_rfd", REG_RFD, 2);  check("alu0_d", REG_D, 16'h1111);
    drive(1'b1, 2'b01, 16'h2222, 4'd9);  tick();
    check("alu1_we", REG_Write, 1); check("alu1_rfd", REG_RFD, 9);  check("alu1_d", REG_D, 16'h2222);
    drive(1'b1, 2'b01, 16'h3333, 4'd15); tick();
    check("alu2_we", REG_Write, 1); check("alu2_rfd", REG_RFD, 15); check("alu2_d", REG_D, 16'h3333);
    drive(1'b0, 2'b00, 16'h0, 4'd0);     tick();
    check("alu_idle_we", REG_Write, 0); check("alu_hold_d", REG_D, 16'h3333); check("alu_hold_rfd", REG_RFD, 15);

    // NOP and reserved are consumed silently
    drive(1'b1, 2'b00, 16'hDEAD, 4'd3); tick();
    check("nop_we", REG_Write, 0); check("nop_req", mem_req, 0);
    drive(1'b1, 2'b11, 16'hDEAD, 4'd3); tick();
    check("rsv_we", REG_Write, 0); check("rsv_req", mem_req, 0); check("rsv_hold_d", REG_D, 16'h3333);

    // LOAD with 3 wait cycles
    drive(1'b1, 2'b10, 16'h0100, 4'd5); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    check("ld_req", mem_req, 1); check("ld_addr", mem_addr, 16'h0100);
    check("ld_busy", wb_busy, 1); check("ld_ready", ex_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_wait_req", mem_req, 1);   check("ld_wait_addr", mem_addr, 16'h0100);
      check("ld_wait_ready", ex_ready, 0); check("ld_wait_we", REG_Write, 0);
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF; tick();
    mem_ack = 1'b0;
    check("ld_we", REG_Write, 1); check("ld_rfd", REG_RFD, 5); check("ld_d", REG_D, 16'hBEEF);
    check("ld_req_drop", mem_req, 0); check("ld_busy_drop", wb_busy, 0); check("ld_ready_back", ex_ready, 1);
    tick();
    check("ld_we_single", REG_Write, 0);

    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 16'h7777; tick();
    mem_ack = 1'b0;
    check("stray_we", REG_Write, 0); check("stray_req", mem_req, 0); check("stray_d", REG_D, 16'hBEEF);

    // writes to R0 / R1 are suppressed; the load still runs
    drive(1'b1, 2'b01, 16'hAAAA, 4'd0); tick();
    check("r0_we", REG_Write, 0); check("r0_d", REG_D, 16'hBEEF); check("r0_rfd", REG_RFD, 5);
    drive(1'b1, 2'b10, 16'h0200, 4'd1); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    check("r1_req", mem_req, 1); check("r1_addr", mem_addr, 16'h0200);
    mem_ack = 1'b1; mem_rdata = 16'h1234; tick();
    mem_ack = 1'b0;
    check("r1_we", REG_Write, 0); check("r1_req_drop", mem_req, 0); check("r1_d", REG_D, 16'hBEEF);

    // minimum latency: ack already high at accept is ignored, then completes next edge
    drive(1'b1, 2'b10, 16'h0300, 4'd3); mem_ack = 1'b1; mem_rdata = 16'h5A5A; tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    check("min_req", mem_req, 1); check("min_we_early", REG_Write, 0);
    tick();
    mem_ack = 1'b0;
    check("min_we", REG_Write, 1); check("min_d", REG_D, 16'h5A5A); check("min_rfd", REG_RFD, 3);

    // reset during an outstanding load
    drive(1'b1, 2'b10, 16'h0040, 4'd4); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    check("rml_req", mem_req, 1);
    rst = 1'b0; #1;
    check("rml_req_clr", mem_req, 0); check("rml_ready", ex_ready, 0);
    check("rml_addr", mem_addr, 0);   check("rml_d", REG_D, 0); check("rml_busy", wb_busy, 0);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF; tick();
    mem_ack = 1'b0; rst = 1'b1; #1;
    check("rml_ready_rel", ex_ready, 1);
    tick();
    check("rml_no_we0", REG_Write, 0);
    tick();
    check("rml_no_we1", REG_Write, 0); check("rml_d_post", REG_D, 0);

`ifdef NRISC_WB_TIMEOUT_EN
    // no ack: mem_req held 15 cycles then aborts
    drive(1'b1, 2'b10, 16'h0500, 4'd6); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("to_wait_req", mem_req, 1); check("to_wait_err", wb_err, 0);
    end
    tick();
    check("to_req_drop", mem_req, 0); check("to_err", wb_err, 1);
    check("to_we", REG_Write, 0);     check("to_ready", ex_ready, 1);
    tick();
    check("to_err_pulse", wb_err, 0);

    // ack on the expiry cycle wins
    drive(1'b1, 2'b10, 16'h0600, 4'd7); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    for (int i = 0; i < 14; i++) tick();
    check("tx_req_last", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hC0DE; tick();
    mem_ack = 1'b0;
    check("tx_we", REG_Write, 1); check("tx_d", REG_D, 16'hC0DE); check("tx_rfd", REG_RFD, 7);
    check("tx_err", wb_err, 0);   check("tx_req_drop", mem_req, 0);
    tick();
    check("tx_err_after", wb_err, 0);
`else
    // without the watchdog a load waits indefinitely
    drive(1'b1, 2'b10, 16'h0700, 4'd8); tick();
    drive(1'b0, 2'b00, 16'h0, 4'd0);
    for (int i = 0; i < 20; i++) tick();
    check("nto_req_held", mem_req, 1); check("nto_err", wb_err, 0); check("nto_addr", mem_addr, 16'h0700);
    mem_ack = 1'b1; mem_rdata = 16'h0ACE; tick();
    mem_ack = 1'b0;
    check("nto_we", REG_Write, 1); check("nto_d", REG_D, 16'h0ACE); check("nto_rfd", REG_RFD, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
